// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
// Shared constants for the parallel ADC capture path: the native sample
// width, the trigger-mode encodings seen on trig_mode and the sequencer
// state encodings.
// Ports: none (package).
// ---------------------------------------------------------------------------
package adc_pkg;

  localparam int ADC_DATA_W = 8;

  // trig_mode encodings; 2'd3 is reserved and behaves like TRIG_IMM
  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;

  // Sequencer states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/adc_clk_gen.sv
// ---------------------------------------------------------------------------
// adc_clk_gen
// Free-running divider producing the ADC conversion clock and a one-cycle
// sample strobe placed in the middle of the ADC clock's low phase.
// Ports:
//   i_clk     system clock
//   i_rst     synchronous reset, active-high
//   o_clk_adc divided clock, 50 % duty, period CLK_DIV system cycles
//   o_stb     one-cycle pulse once per ADC period (cnt == CLK_DIV/4)
// ---------------------------------------------------------------------------
module adc_clk_gen #(
  parameter int CLK_DIV = 100
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_clk_adc,
  output logic o_stb
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_QTR = CNT_W'(CLK_DIV / 4);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_adc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_clk_adc <= 1'b0;
    end else begin
      r_cnt     <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
      r_clk_adc <= (r_cnt >= CNT_HALF);
    end
  end

  // The ADC launches data on the clk_ADC rising edge; sampling a quarter
  // period into the low phase keeps us clear of that transition.
  assign o_stb     = (r_cnt == CNT_QTR);
  assign o_clk_adc = r_clk_adc;

endmodule

// File: rtl/adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// adc_capture_ctrl
// Capture sequencer for the 8-bit parallel ADC front end. Generates the ADC
// clock and enable, waits for a trigger on the sample stream after each
// start, stores DEPTH consecutive samples in an internal block RAM and
// raises a sticky done. The readout logic reads the buffer through a
// registered read port.
// Ports:
//   clk_100MHz  system clock
//   Rst         synchronous reset, active-high
//   start       one-cycle pulse, arms a capture (ignored while busy)
//   abort       one-cycle pulse, cancels ARM/CAPTURE (wins over start)
//   trig_mode   0 immediate, 1 rising crossing, 2 falling crossing, 3 = 0
//   trig_level  unsigned trigger threshold
//   adc_data    parallel ADC output
//   clk_ADC     divided ADC clock
//   ADC_En      ADC enable, active-low
//   busy        high in ARM or CAPTURE
//   done        high once the buffer is full, until the next start
//   rd_addr     buffer read address
//   rd_data     buffer read data, 1-cycle latency, read-first
// ---------------------------------------------------------------------------
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 100,
  parameter int DATA_W  = ADC_DATA_W,
  parameter int ADDR_W  = 10
) (
  input  logic              clk_100MHz,
  input  logic              Rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DATA_W-1:0] adc_data,
  output logic              clk_ADC,
  output logic              ADC_En,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Trigger decision for one new sample. Rising/falling crossings need a
  // valid previous sample so the first sample after start cannot fire.
  function automatic logic f_trig(
    input logic [1:0]        mode,
    input logic [DATA_W-1:0] prev,
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] level,
    input logic              prev_ok
  );
    case (mode)
      TRIG_IMM:  return 1'b1;
      TRIG_RISE: return prev_ok && (prev < level) && (cur >= level);
      TRIG_FALL: return prev_ok && (prev >= level) && (cur < level);
      default:   return 1'b1;
    endcase
  endfunction

  logic              w_clk_adc;
  logic              w_stb;
  logic              w_trig;
  logic              w_we;
  logic [ADDR_W-1:0] w_wr_addr;

  logic              r_en_n;
  logic [DATA_W-1:0] r_cur;
  logic              r_new;
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_valid;
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  adc_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_clk     (clk_100MHz),
    .i_rst     (Rst),
    .o_clk_adc (w_clk_adc),
    .o_stb     (w_stb)
  );

  assign w_trig = f_trig(trig_mode, r_prev, r_cur, trig_level, r_prev_valid);

  // Buffer write request. A sample is consumed on the cycle after the
  // strobe (r_new). abort and Rst suppress the write of that cycle.
  always_comb begin
    w_we      = 1'b0;
    w_wr_addr = r_wr_addr;
    if (r_new && !abort && !Rst) begin
      if (r_state == ST_ARM && w_trig) begin
        w_we      = 1'b1;
        w_wr_addr = '0;
      end else if (r_state == ST_CAPTURE) begin
        w_we = 1'b1;
      end
    end
  end

  // Sample register, enable and sequencer
  always_ff @(posedge clk_100MHz) begin
    if (Rst) begin
      r_en_n       <= 1'b1;
      r_cur        <= '0;
      r_new        <= 1'b0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_state      <= ST_IDLE;
      r_wr_addr    <= '0;
    end else begin
      r_en_n <= 1'b0;
      r_new  <= w_stb;
      if (w_stb) begin
        r_cur <= adc_data;
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            r_state      <= ST_ARM;
            r_prev_valid <= 1'b0;
          end
        end
        ST_ARM: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (r_new) begin
            r_prev       <= r_cur;
            r_prev_valid <= 1'b1;
            if (w_trig) begin
              r_wr_addr <= ADDR_W'(1);
              r_state   <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (r_new) begin
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
            if (r_wr_addr == LAST_ADDR) begin
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Buffer RAM: write port, no reset on contents
  always_ff @(posedge clk_100MHz) begin
    if (w_we) begin
      r_mem[w_wr_addr] <= r_cur;
    end
  end

  // Registered read port (read-first), cleared by reset
  always_ff @(posedge clk_100MHz) begin
    if (Rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign clk_ADC = w_clk_adc;
  assign ADC_En  = r_en_n;
  assign busy    = (r_state == ST_ARM) || (r_state == ST_CAPTURE);
  assign done    = (r_state == ST_DONE);
  assign rd_data = r_rd_data;

endmodule
